// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus master, its interface and the memory block.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } mem_master_state_e;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    localparam int unsigned MEM_ADDR_W = 4;
    localparam int unsigned MEM_DATA_W = 8;

    localparam int unsigned STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Command/response port and memory-side bus of mem_bus_master, bundled with master/slave views.
interface mem_bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_wr_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;

    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    logic [ADDR_W-1:0] paddr_o;
    logic              pwr_rd_o;
    logic              penable_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;

    modport master (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               paddr_o, pwr_rd_o, penable_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               paddr_o, pwr_rd_o, penable_o, pwdata_o
    );

endinterface

// File: rtl/mem_master_timeout.sv
// Access-phase wait counter: clear/load/enable, flags when TIMEOUT_CYC-1 cycles have elapsed.
module mem_master_timeout #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       expire
);
    localparam int unsigned   CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding initiator for the simple memory bus (IDLE/SETUP/ACCESS/RESP).
// Define MEM_MASTER_STATS_EN to add saturating write/read/timeout counters.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = MEM_ADDR_W,
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              pclk_i,
    input  logic              prst_n_i,
    mem_bus_master_if.master  bus
`ifdef MEM_MASTER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wr_o,
    output logic [STAT_W-1:0] stat_rd_o,
    output logic [STAT_W-1:0] stat_err_o
`endif
);
    mem_master_state_e state_q, state_d;

    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwr_rd_q;
    logic              wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic accept;
    logic done;
    logic timeout_hit;
    logic expire;

    assign accept      = (state_q == IDLE) && bus.cmd_valid_i;
    assign done        = (state_q == ACCESS) && bus.pready_i;
    assign timeout_hit = (state_q == ACCESS) && !bus.pready_i && expire;

    mem_master_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (pclk_i),
        .rst_n    (prst_n_i),
        .clr      (state_q == RESP),
        .load     (accept),
        .load_val ('0),
        .en       (state_q == ACCESS),
        .expire   (expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // wr_q keeps the command type through RESP after pwr_rd_o has already dropped.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwr_rd_q <= 1'b0;
            wr_q     <= 1'b0;
        end else if (accept) begin
            paddr_q  <= bus.cmd_addr_i;
            pwdata_q <= bus.cmd_wdata_i;
            pwr_rd_q <= bus.cmd_wr_i;
            wr_q     <= bus.cmd_wr_i;
        end else if (done || timeout_hit) begin
            pwr_rd_q <= 1'b0;
        end
    end

    // Response fields are only non-zero during the RESP cycle.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= (done && wr_q == RD) ? bus.prdata_i : '0;
            err_q   <= timeout_hit;
        end
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwr_rd_o    = pwr_rd_q;
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.pwdata_o    = pwdata_q;

`ifdef MEM_MASTER_STATS_EN
    logic [STAT_W-1:0] stat_wr_q;
    logic [STAT_W-1:0] stat_rd_q;
    logic [STAT_W-1:0] stat_err_q;

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            stat_wr_q  <= '0;
            stat_rd_q  <= '0;
            stat_err_q <= '0;
        end else if (state_q == RESP) begin
            if (err_q) begin
                stat_err_q <= sat_inc(stat_err_q);
            end else if (wr_q == WR) begin
                stat_wr_q <= sat_inc(stat_wr_q);
            end else begin
                stat_rd_q <= sat_inc(stat_rd_q);
            end
        end
    end

    assign stat_wr_o  = stat_wr_q;
    assign stat_rd_o  = stat_rd_q;
    assign stat_err_o = stat_err_q;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomised scoreboard bench for mem_bus_master with a reactive memory responder.
// Honours MEM_MASTER_STATS_EN when the design is built with it.
module tb_mem_bus_master;

    localparam int TO = 16;

    logic clk;
    logic prst_n;

    mem_bus_master_if #(.ADDR_W(4), .DATA_W(8)) bus ();

`ifdef MEM_MASTER_STATS_EN
    logic [15:0] stat_wr, stat_rd, stat_err;
    int          m_wr, m_rd, m_err;
`endif

    mem_bus_master #(
        .ADDR_W      (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk_i   (clk),
        .prst_n_i (prst_n),
        .bus      (bus)
`ifdef MEM_MASTER_STATS_EN
        ,
        .stat_wr_o  (stat_wr),
        .stat_rd_o  (stat_rd),
        .stat_err_o (stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] rdata;
        logic       err;
        int         pen;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem[16];
    logic [7:0] ref_mem[16];
    int         cur_delay;
    int         resp_k;
    int         checks;
    int         errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory responder: pready after cur_delay wait cycles; random pready noise outside ACCESS.
    initial begin
        resp_k = 0;
        forever begin
            @(negedge clk);
            if (prst_n && bus.penable_o) begin
                if (resp_k == cur_delay) begin
                    bus.pready_i = 1'b1;
                    bus.prdata_i = mem[bus.paddr_o];
                    if (bus.pwr_rd_o) mem[bus.paddr_o] = bus.pwdata_o;
                end else begin
                    bus.pready_i = 1'b0;
                    bus.prdata_i = 8'($urandom);
                end
                resp_k++;
            end else begin
                resp_k = 0;
                bus.pready_i = 1'($urandom_range(0, 1));
                bus.prdata_i = 8'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard on each response pulse.
    initial begin
        int   pen_cnt;
        logic prev_pen;
        exp_t e;
        pen_cnt  = 0;
        prev_pen = 1'b0;
        forever begin
            @(negedge clk);
            if (!prst_n) begin
                pen_cnt  = 0;
                prev_pen = 1'b0;
                continue;
            end
            if (bus.penable_o) begin
                pen_cnt++;
                if (exp_q.size() > 0) begin
                    check("access_paddr", 32'(bus.paddr_o), 32'(exp_q[0].addr));
                    check("access_pwr_rd", 32'(bus.pwr_rd_o), 32'(exp_q[0].wr));
                end
            end
            if (bus.rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid 1, expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", 32'(bus.rsp_rdata_o), 32'(e.rdata));
                    check("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
                    check("penable_cycles", 32'(pen_cnt), 32'(e.pen));
                    check("rsp_after_access", 32'(prev_pen), 32'd1);
                    check("rsp_pwr_rd", 32'(bus.pwr_rd_o), 32'd0);
                    check("rsp_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
                end
                pen_cnt = 0;
            end else begin
                check("idle_rsp_fields", {23'd0, bus.rsp_err_o, bus.rsp_rdata_o}, 32'd0);
            end
            prev_pen = bus.penable_o;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready_o) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: got 0 after 200 cycles, expected 1");
        end
    endtask

    task automatic issue(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                         input int delay);
        exp_t e;
        wait_ready();
        cur_delay = delay;
        e.wr    = wr;
        e.addr  = addr;
        e.err   = (delay >= TO);
        e.rdata = (!wr && !e.err) ? ref_mem[addr] : 8'h00;
        e.pen   = e.err ? TO : delay + 1;
        if (wr && !e.err) ref_mem[addr] = wdata;
`ifdef MEM_MASTER_STATS_EN
        if (e.err) m_err++;
        else if (wr) m_wr++;
        else m_rd++;
`endif
        exp_q.push_back(e);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_wr_i    = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wdata;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_wdata_i = 8'($urandom);
        bus.cmd_addr_i  = 4'($urandom);
        @(negedge clk);
        check("setup_penable", 32'(bus.penable_o), 32'd0);
        check("setup_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        check("setup_paddr", 32'(bus.paddr_o), 32'(addr));
        check("setup_pwr_rd", 32'(bus.pwr_rd_o), 32'(wr));
        check("setup_pwdata", 32'(bus.pwdata_o), 32'(wdata));
        @(negedge clk);
        check("access_after_setup", 32'(bus.penable_o), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic check_stats();
`ifdef MEM_MASTER_STATS_EN
        check("stat_wr", 32'(stat_wr), 32'(m_wr));
        check("stat_rd", 32'(stat_rd), 32'(m_rd));
        check("stat_err", 32'(stat_err), 32'(m_err));
`endif
    endtask

    task automatic stats_reset();
`ifdef MEM_MASTER_STATS_EN
        m_wr  = 0;
        m_rd  = 0;
        m_err = 0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         r;
        int         d;
        logic [7:0] v;
        checks = 0;
        errors = 0;
        cur_delay = 0;
        stats_reset();
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        bus.cmd_valid_i = 1'b0;
        bus.cmd_wr_i    = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.pready_i    = 1'b0;
        bus.prdata_i    = '0;

        prst_n = 1'b0;
        repeat (2) @(negedge clk);
        prst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rst_penable", 32'(bus.penable_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_pwr_rd", 32'(bus.pwr_rd_o), 32'd0);
        check("rst_paddr", 32'(bus.paddr_o), 32'd0);
        check_stats();

        issue(1'b1, 4'h3, 8'hA5, 0);
        issue(1'b0, 4'h3, 8'h00, 0);
        wait_idle();
        check_stats();
        issue(1'b0, 4'h7, 8'h00, 5);
        issue(1'b0, 4'h2, 8'h00, TO - 1);
        issue(1'b1, 4'h9, 8'h5A, TO - 1);
        issue(1'b0, 4'h4, 8'h00, 40);
        issue(1'b1, 4'h6, 8'hC3, TO);
        issue(1'b0, 4'h6, 8'h00, 1);
        wait_idle();
        check_stats();

        // Reset during ACCESS: penable must drop without waiting for a clock edge.
        wait_ready();
        cur_delay = 40;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_wr_i    = 1'b1;
        bus.cmd_addr_i  = 4'h5;
        bus.cmd_wdata_i = 8'hEE;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_access", 32'(bus.penable_o), 32'd1);
        #2;
        prst_n = 1'b0;
        #1;
        check("abort_penable_async", 32'(bus.penable_o), 32'd0);
        check("abort_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        stats_reset();
        repeat (2) @(negedge clk);
        prst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check_stats();
        issue(1'b1, 4'hF, 8'h3C, 0);
        issue(1'b0, 4'hF, 8'h00, 2);

        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 9));
            d = (r < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 20));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), d);
        end
        wait_idle();
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
